fetch_queue: RTL and testbench

- Instruction fetch stage directly downstream of the program counter.
- Accepts PC values over a valid/ready handshake and issues them to instruction memory over a req/gnt interface.
- Collects in-order read responses with variable latency and pairs each instruction with its PC in a DEPTH-entry buffer.
- Presents {pc, instr} to decode over valid/ready; a flush input, driven on a taken branch, discards all queued and in-flight fetches.

---
 rtl/fetch_pkg.sv | 15 +
 rtl/fetch_queue_if.sv | 31 +++
 rtl/fetch_queue.sv | 102 ++++++++++
 tb/tb_fetch_queue.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch-path sizing and the buffered entry type; decode reuses it for its input register.
package fetch_pkg;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [WIDTH-1:0] pc;
        logic [WIDTH-1:0] instr;
        logic             filled;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch queue signal bundle: PC handshake, instruction memory req/gnt/rvalid, decode handshake, flush.
interface fetch_queue_if;
    import fetch_pkg::*;

    logic [WIDTH-1:0] pc_in;
    logic             pc_valid;
    logic             pc_ready;
    logic             imem_req;
    logic [WIDTH-1:0] imem_addr;
    logic             imem_gnt;
    logic             imem_rvalid;
    logic [WIDTH-1:0] imem_rdata;
    logic             flush;
    logic             out_valid;
    logic [WIDTH-1:0] out_pc;
    logic [WIDTH-1:0] out_instr;
    logic             out_ready;

    // Fetch queue side
    modport slave (
        input  pc_in, pc_valid, imem_gnt, imem_rvalid, imem_rdata, flush, out_ready,
        output pc_ready, imem_req, imem_addr, out_valid, out_pc, out_instr
    );

    // Surrounding PC stage, memory and decode
    modport master (
        output pc_in, pc_valid, imem_gnt, imem_rvalid, imem_rdata, flush, out_ready,
        input  pc_ready, imem_req, imem_addr, out_valid, out_pc, out_instr
    );

endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch queue: credit-limited memory requests, in-order fill of a circular buffer,
// and flush that turns in-flight responses into a drop count.
module fetch_queue
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    fetch_queue_if.slave bus
);

    fetch_entry_t     entry_q [DEPTH];
    logic [PTR_W-1:0] alloc_ptr;
    logic [PTR_W-1:0] fill_ptr;
    logic [PTR_W-1:0] head_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] drop_cnt;

    logic [CNT_W-1:0] filled_cnt;
    logic [CNT_W-1:0] unfilled;
    logic [CNT_W-1:0] drop_flush;
    logic             credit_ok;
    logic             req;
    logic             alloc;
    logic             fill;
    logic             pop;

    // Filled entries are exactly the allocated ones already answered, so unfilled needs no extra state
    always_comb begin
        filled_cnt = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            filled_cnt = filled_cnt + CNT_W'(entry_q[i].filled);
        end
    end

    always_comb begin
        unfilled  = count - filled_cnt;
        credit_ok = ({1'b0, count} + {1'b0, drop_cnt}) < (CNT_W + 1)'(DEPTH);
        // No request escapes while held in reset
        req       = rst & bus.pc_valid & credit_ok & ~bus.flush;

        bus.imem_req  = req;
        bus.imem_addr = bus.pc_in;
        bus.pc_ready  = req & bus.imem_gnt;
        bus.out_valid = entry_q[head_ptr].filled & ~bus.flush;
        bus.out_pc    = entry_q[head_ptr].pc;
        bus.out_instr = entry_q[head_ptr].instr;

        alloc = req & bus.imem_gnt;
        fill  = bus.imem_rvalid & (drop_cnt == '0) & (unfilled != '0);
        pop   = entry_q[head_ptr].filled & ~bus.flush & bus.out_ready;

        // A response landing in the flush cycle is itself one of the discarded ones
        drop_flush = drop_cnt + unfilled
                   - CNT_W'(bus.imem_rvalid & ((drop_cnt != '0) | (unfilled != '0)));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            head_ptr  <= '0;
            count     <= '0;
            drop_cnt  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                entry_q[i] <= '0;
            end
        end else if (bus.flush) begin
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            head_ptr  <= '0;
            count     <= '0;
            drop_cnt  <= drop_flush;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                entry_q[i].filled <= 1'b0;
            end
        end else begin
            // Allocate, fill and pop always touch distinct entries
            if (alloc) begin
                entry_q[alloc_ptr].pc     <= bus.pc_in;
                entry_q[alloc_ptr].filled <= 1'b0;
                alloc_ptr                 <= alloc_ptr + PTR_W'(1);
            end
            if (bus.imem_rvalid && drop_cnt != '0) begin
                drop_cnt <= drop_cnt - CNT_W'(1);
            end else if (fill) begin
                entry_q[fill_ptr].instr  <= bus.imem_rdata;
                entry_q[fill_ptr].filled <= 1'b1;
                fill_ptr                 <= fill_ptr + PTR_W'(1);
            end
            if (pop) begin
                entry_q[head_ptr].filled <= 1'b0;
                head_ptr                 <= head_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(alloc) - CNT_W'(pop);
        end
    end

    // A response with nothing outstanding means the memory broke the in-order contract
    assert property (@(posedge clk) disable iff (!rst)
        !(bus.imem_rvalid && drop_cnt == '0 && unfilled == '0));

endmodule

// File: tb/tb_fetch_queue.sv
// Directed and randomized bench for fetch_queue against a queue-based reference model.
module tb_fetch_queue;
    import fetch_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fetch_queue_if bus ();
    fetch_queue dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct { logic [31:0] pc; logic [31:0] instr; bit filled; } ment_t;
    typedef struct { logic [31:0] data; int due; } mrsp_t;

    ment_t       mq[$];
    int          drops;
    mrsp_t       memq[$];
    bit          mem_auto;
    int          cyc;
    int          checks;
    int          failures;
    int          n_acc;
    bit          last_acc;
    logic [31:0] log_pc[$];
    logic [31:0] log_instr[$];
    int          log_cyc[$];

    function automatic logic [31:0] instr_of(logic [31:0] pc);
        return (pc * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.pc_valid    = 1'b0;
        bus.pc_in       = 32'h0;
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'h0;
        bus.flush       = 1'b0;
        bus.out_ready   = 1'b0;
    endtask

    // One clock: check outputs against the model, then advance the model across the edge.
    task automatic tick();
        bit e_req, e_ov, e_pop, e_acc, rv;
        int unf, due;
        if (mem_auto) begin
            if (memq.size() > 0 && memq[0].due <= cyc) begin
                bus.imem_rvalid = 1'b1;
                bus.imem_rdata  = memq[0].data;
            end else begin
                bus.imem_rvalid = 1'b0;
                bus.imem_rdata  = $urandom;
            end
            chk("outstanding_le_depth", 32'(memq.size() <= int'(DEPTH)), 32'd1);
        end
        #3;
        e_req = rst && bus.pc_valid && (mq.size() + drops < int'(DEPTH)) && !bus.flush;
        e_acc = e_req && bus.imem_gnt;
        e_ov  = rst && mq.size() > 0 && mq[0].filled && !bus.flush;
        chk("imem_req", 32'(bus.imem_req), 32'(e_req));
        chk("pc_ready", 32'(bus.pc_ready), 32'(e_acc));
        chk("out_valid", 32'(bus.out_valid), 32'(e_ov));
        if (e_req) chk("imem_addr", bus.imem_addr, bus.pc_in);
        if (e_ov) begin
            chk("out_pc", bus.out_pc, mq[0].pc);
            chk("out_instr", bus.out_instr, mq[0].instr);
        end
        if (bus.out_valid && bus.out_ready) begin
            log_pc.push_back(bus.out_pc);
            log_instr.push_back(bus.out_instr);
            log_cyc.push_back(cyc);
        end
        last_acc = bus.pc_ready;
        if (bus.pc_ready) n_acc++;
        e_pop = e_ov && bus.out_ready;
        rv    = bus.imem_rvalid;

        if (mem_auto) begin
            if (rv) void'(memq.pop_front());
            if (bus.imem_req && bus.imem_gnt) begin
                due = cyc + $urandom_range(1, 5);
                if (memq.size() > 0 && due <= memq[$].due) due = memq[$].due + 1;
                memq.push_back('{data: instr_of(bus.pc_in), due: due});
            end
        end

        if (bus.flush) begin
            unf = 0;
            foreach (mq[i]) if (!mq[i].filled) unf++;
            drops = drops + unf - (rv ? 1 : 0);
            mq.delete();
        end else begin
            if (rv) begin
                if (drops > 0) drops--;
                else begin
                    for (int i = 0; i < mq.size(); i++) begin
                        if (!mq[i].filled) begin
                            mq[i].instr  = bus.imem_rdata;
                            mq[i].filled = 1'b1;
                            break;
                        end
                    end
                end
            end
            if (e_pop) void'(mq.pop_front());
            if (e_acc) mq.push_back('{pc: bus.pc_in, instr: 32'h0, filled: 1'b0});
        end
        @(posedge clk);
        if (!rst) begin
            mq.delete();
            drops = 0;
        end
        #1;
        cyc++;
    endtask

    logic [31:0] rd_tbl [3];
    int          base;
    int          c0;
    int          n0;
    logic [31:0] p;
    bit          flush_last;

    initial begin
        rd_tbl = '{32'h0050_0093, 32'h0010_0113, 32'h0020_81B3};
        checks = 0; failures = 0; drops = 0; cyc = 0; n_acc = 0; mem_auto = 1'b0;
        idle();
        @(posedge clk); #1;

        // Reset state, with a valid PC waiting
        bus.pc_valid = 1'b1; bus.pc_in = 32'h100; bus.imem_gnt = 1'b1;
        tick(); tick();
        rst = 1'b1;

        // Queue three entries, the first one answered
        for (int k = 0; k < 3; k++) begin
            bus.pc_valid    = 1'b1;
            bus.pc_in       = 32'h100 + 32'(4 * k);
            bus.imem_gnt    = 1'b1;
            bus.imem_rvalid = (k == 2);
            bus.imem_rdata  = instr_of(32'h100);
            tick();
        end
        idle();
        bus.pc_valid = 1'b1; bus.pc_in = 32'h10C; bus.imem_gnt = 1'b1;
        #3;
        chk("pre_reset_out_valid", 32'(bus.out_valid), 32'd1);
        #1 rst = 1'b0;
        #1;
        chk("async_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("async_rst_imem_req", 32'(bus.imem_req), 32'd0);
        chk("async_rst_pc_ready", 32'(bus.pc_ready), 32'd0);
        mq.delete(); drops = 0;
        @(posedge clk); #1; cyc++;
        tick();
        rst = 1'b1;

        // Post-reset fetch of 0x0
        base = log_pc.size();
        idle();
        bus.pc_valid = 1'b1; bus.pc_in = 32'h0; bus.imem_gnt = 1'b1; bus.out_ready = 1'b1;
        tick();
        bus.pc_valid = 1'b0; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h0050_0093;
        tick();
        bus.imem_rvalid = 1'b0;
        tick();
        chk("post_reset_count", 32'(log_pc.size() - base), 32'd1);
        chk("post_reset_pc", log_pc[$], 32'h0);
        chk("post_reset_instr", log_instr[$], 32'h0050_0093);

        // Streaming at one-cycle latency
        idle();
        base = log_pc.size();
        c0   = cyc;
        for (int k = 0; k < 6; k++) begin
            bus.pc_valid  = (k < 3);
            bus.pc_in     = 32'(4 * k);
            bus.imem_gnt  = 1'b1;
            bus.out_ready = 1'b1;
            bus.imem_rvalid = 1'b0;
            bus.imem_rdata  = 32'h0;
            if (k >= 1 && k <= 3) begin
                bus.imem_rvalid = 1'b1;
                bus.imem_rdata  = rd_tbl[k-1];
            end
            tick();
        end
        chk("stream_count", 32'(log_pc.size() - base), 32'd3);
        for (int j = 0; j < 3; j++) begin
            chk("stream_pc", log_pc[base+j], 32'(4 * j));
            chk("stream_instr", log_instr[base+j], rd_tbl[j]);
            chk("stream_cycle", 32'(log_cyc[base+j] - c0), 32'(2 + j));
        end

        // Backpressure: four credits, then one more after a single pop
        idle();
        base = log_pc.size();
        n0   = n_acc;
        p    = 32'h0;
        for (int k = 0; k < 6; k++) begin
            bus.pc_valid = 1'b1; bus.pc_in = p; bus.imem_gnt = 1'b1;
            tick();
            if (last_acc) p += 4;
        end
        chk("bp_accepts", 32'(n_acc - n0), 32'd4);
        chk("bp_next_pc", p, 32'h10);
        for (int k = 0; k < 4; k++) begin
            bus.imem_rvalid = 1'b1; bus.imem_rdata = instr_of(32'(4 * k));
            tick();
        end
        bus.imem_rvalid = 1'b0;
        bus.out_ready   = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.pc_in = p;
            tick();
            if (last_acc) p += 4;
        end
        chk("bp_accepts_after_pop", 32'(n_acc - n0), 32'd5);
        bus.pc_valid = 1'b0;
        bus.imem_rvalid = 1'b1; bus.imem_rdata = instr_of(32'h10);
        tick();
        bus.imem_rvalid = 1'b0;
        bus.out_ready   = 1'b1;
        for (int k = 0; k < 6; k++) tick();
        chk("bp_drained", 32'(log_pc.size() - base), 32'd5);
        chk("bp_last_pc", log_pc[$], 32'h10);

        // Flush with one buffered and two in flight
        idle();
        for (int k = 0; k < 3; k++) begin
            bus.pc_valid = 1'b1; bus.pc_in = 32'h20 + 32'(4 * k); bus.imem_gnt = 1'b1;
            bus.imem_rvalid = (k == 1); bus.imem_rdata = instr_of(32'h20);
            tick();
        end
        idle();
        base = log_pc.size();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0; bus.out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hDEAD_0001 + 32'(k);
            tick();
        end
        bus.imem_rvalid = 1'b0;
        chk("flush_no_output", 32'(log_pc.size() - base), 32'd0);
        bus.pc_valid = 1'b1; bus.pc_in = 32'h40; bus.imem_gnt = 1'b1;
        tick();
        bus.pc_valid = 1'b0; bus.imem_rvalid = 1'b1; bus.imem_rdata = instr_of(32'h40);
        tick();
        bus.imem_rvalid = 1'b0;
        tick();
        chk("flush_refetch_count", 32'(log_pc.size() - base), 32'd1);
        chk("flush_refetch_pc", log_pc[$], 32'h40);
        chk("flush_refetch_instr", log_instr[$], instr_of(32'h40));

        // Flush coincident with a response, two unfilled
        idle();
        for (int k = 0; k < 2; k++) begin
            bus.pc_valid = 1'b1; bus.pc_in = 32'h60 + 32'(4 * k); bus.imem_gnt = 1'b1;
            tick();
        end
        idle();
        base = log_pc.size();
        bus.flush = 1'b1; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hBAD0_0060;
        tick();
        idle();
        bus.out_ready = 1'b1;
        bus.pc_valid = 1'b1; bus.pc_in = 32'h80; bus.imem_gnt = 1'b1;
        tick();
        bus.pc_valid = 1'b0; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hBAD0_0064;
        tick();
        bus.imem_rdata = instr_of(32'h80);
        tick();
        bus.imem_rvalid = 1'b0;
        tick();
        chk("coflush_count", 32'(log_pc.size() - base), 32'd1);
        chk("coflush_pc", log_pc[$], 32'h80);
        chk("coflush_instr", log_instr[$], instr_of(32'h80));

        // Randomized traffic with variable latency and grant stalls
        idle();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        mem_auto   = 1'b1;
        base       = log_pc.size();
        p          = 32'h1000;
        flush_last = 1'b0;
        last_acc   = 1'b0;
        c0         = cyc;
        while (log_pc.size() - base < 1000 && cyc - c0 < 30000) begin
            if (last_acc) p += 4;
            if (flush_last) p = 32'($urandom_range(0, 1023)) << 2;
            if (!(bus.pc_valid && !last_acc && !flush_last))
                bus.pc_valid = ($urandom_range(0, 3) != 0);
            bus.pc_in     = p;
            bus.imem_gnt  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.flush     = ($urandom_range(0, 49) == 0);
            flush_last    = bus.flush;
            n0 = log_pc.size();
            tick();
            if (log_pc.size() > n0) chk("rand_pairing", log_instr[$], instr_of(log_pc[$]));
        end
        chk("rand_completed", 32'(log_pc.size() - base >= 1000), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
